// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//
// Samples an asynchronous serial line in the middle of each bit period. It
// checks the start and stop bits and delivers each good byte with a
// one-cycle strobe. A low stop bit raises a one-cycle frame-error strobe.
// The receiver then waits for the line to return high before it looks for
// the next start bit.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         serial line, asynchronous to clk, idle high
//   data       last correctly received byte (holds until the next good byte)
//   data_valid one-cycle strobe: data updated this cycle
//   frame_err  one-cycle strobe: stop bit sampled low
//   busy       high whenever the receiver is not idle
//
// CLKS_PER_BIT must be at least 4 so that the half-bit count is non-zero.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_s;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  // Two-flop synchronizer. Both flops reset to the idle level, so a reset
  // release never looks like a start edge.
  // NOTE: sequential state is always written with non-blocking (<=) assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; only the stop-bit branch raises them.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The wire sends LSB first, so each bit enters at the MSB and moves right.
        DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Go back to IDLE at the stop-bit mid-sample. A start bit that follows
        // straight after the stop bit is then caught with no idle gap.
        STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data       <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A line break holds rx low. Stay here until it goes high again.
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
